fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main/ALU decoder.
- Owns the PC register and fetches instructions over a request/grant/response instruction-memory interface.
- Holds each fetched instruction stable with a valid/ready handshake and presents the decoder fields op, funct3 and funct7b5.
- Computes the next PC from the decoder's branch decision (PCSrc) and the extended immediate (ImmExt).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- WAIT_TIMEOUT, 255, maximum cycles spent in S_WAIT without imem_rvalid before entering error; range 1..255.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous reset, active-high.
- imem_req  output  1  fetch request; high only in S_REQ.
- imem_addr  output  32  fetch address; always equals pc.
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- instr  output  32  held instruction.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7b5  output  1  instr[30].
- pc  output  32  address of the held instruction.
- pc_plus4  output  32  pc + 4.
- instr_valid  output  1  instr/pc are valid.
- instr_ready  input  1  downstream consumes instruction this cycle.
- PCSrc  input  1  branch taken, sampled in the consume cycle.
- ImmExt  input  32  branch offset, sampled in the consume cycle.
- fetch_err  output  1  sticky error flag.

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (reset).
- Reset values:
  - state=S_REQ, pc=RESET_PC, instr=32'h0000_0000 (so op=0, funct3=0, funct7b5=0).
  - instr_valid=0, fetch_err=0, wait counter=0.
  - imem_req=1 from the first cycle after reset.
- State S_REQ:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> S_WAIT, counter cleared.
  - imem_rvalid in S_REQ is ignored.
- State S_WAIT:
  - imem_req=0; counter increments each cycle.
  - imem_rvalid=1 -> instr<=imem_rdata, instr_valid<=1, go to S_HOLD.
  - Otherwise, when counter==WAIT_TIMEOUT-1 -> S_ERR.
  - rvalid in the same cycle as the timeout condition wins (data accepted).
- State S_HOLD:
  - instr_valid=1; instr and pc held stable while instr_ready=0.
  - Consume = instr_valid & instr_ready. Then next_pc = PCSrc ? pc+ImmExt : pc+4, computed mod 2^32 (wrap, no carry out).
  - If next_pc[1:0]!=0 -> S_ERR, instr_valid<=0, pc unchanged.
  - Otherwise pc<=next_pc, instr_valid<=0, go to S_REQ.
- State S_ERR:
  - fetch_err=1, imem_req=0, instr_valid=0.
  - Terminal; left only via reset.
- PCSrc and ImmExt are don't-care outside consume cycles.
- Latency: minimum 3 cycles per instruction (REQ with gnt, WAIT with rvalid, HOLD with ready). instr_valid rises the cycle after rvalid.
- One outstanding request at most; rvalid arriving outside S_WAIT is dropped.
- Reset mid-operation (any state) returns to S_REQ with pc=RESET_PC next cycle. Memory shares the same reset, so no stale response is expected.
- pc_plus4 is combinational from pc; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- op, funct3 and funct7b5 are pure slices of instr.

Test Plan:
- Reset, gnt same cycle as req, rvalid next cycle with 32'h0062_02B3 -> imem_addr=0; instr_valid high cycle 3; op=7'h33, funct3=0, funct7b5=0; ready=1, PCSrc=0 -> next imem_addr=4.
- Hold instr_ready=0 for 5 cycles -> instr/pc stable, imem_req=0; then ready=1 -> pc advances exactly once.
- Consume at pc=8 with PCSrc=1, ImmExt=32'hFFFF_FFF8 -> next imem_addr=0; with ImmExt=32'h0000_0006 -> fetch_err=1, imem_req stays 0.
- gnt delayed 4 cycles; rvalid withheld WAIT_TIMEOUT cycles -> fetch_err=1; in a separate run, rvalid on the last allowed cycle -> instr accepted, no error.
- pc=32'hFFFF_FFFC, PCSrc=0 -> next imem_addr=0, pc_plus4 was 0.
- Assert reset while in S_HOLD and in S_ERR -> next cycle instr_valid=0, fetch_err=0, imem_req=1, imem_addr=RESET_PC; spurious rvalid in S_REQ ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid memory
// interface and holds each instruction for the decoder under valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(WAIT_TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic        valid_r, valid_s;
  logic        err_r, err_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [31:0] target_s;

  assign target_s = PCSrc ? (pc_r + ImmExt) : (pc_r + 32'd4);

  // Next-state and next-value logic for every register in the stage.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    valid_s = valid_r;
    err_s   = err_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_REQ: begin
        valid_s = 1'b0;
        if (imem_gnt) begin
          state_s = S_WAIT;
          cnt_s   = 8'd0;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_s = cnt_r + 8'd1;
        // A response on the final allowed cycle still beats the timeout.
        if (imem_rvalid) begin
          instr_s = imem_rdata;
          valid_s = 1'b1;
          state_s = S_HOLD;
        end else if (cnt_r == LAST_WAIT) begin
          state_s = S_ERR;
          err_s   = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (valid_r && instr_ready) begin
          valid_s = 1'b0;
          if (target_s[1:0] != 2'b00) begin
            state_s = S_ERR;
            err_s   = 1'b1;
          end else begin
            pc_s    = target_s;
            state_s = S_REQ;
          end
        end else begin
          state_s = S_HOLD;
        end
      end
      S_ERR: begin
        valid_s = 1'b0;
        err_s   = 1'b1;
      end
      default: begin
        state_s = S_ERR;
        valid_s = 1'b0;
        err_s   = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_REQ;
      pc_r    <= RESET_PC;
      instr_r <= 32'h0000_0000;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      instr_r <= instr_s;
      valid_r <= valid_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  assign imem_req    = (state_r == S_REQ);
  assign imem_addr   = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_r + 32'd4;
  assign instr       = instr_r;
  assign op          = instr_r[6:0];
  assign funct3      = instr_r[14:12];
  assign funct7b5    = instr_r[30];
  assign instr_valid = valid_r;
  assign fetch_err   = err_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a short wait timeout.
module tb_fetch_unit;

  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .PCSrc(PCSrc), .ImmExt(ImmExt),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] word, input int gnt_dly, input int rv_dly);
    for (int i = 0; i < gnt_dly; i++) begin
      step();
      check("req_while_no_gnt", {31'd0, imem_req}, 32'd1);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("req_low_in_wait", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rv_dly; i++) step();
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    step();
    imem_rvalid = 1'b0;
    check("valid_after_rvalid", {31'd0, instr_valid}, 32'd1);
    check("instr_captured", instr, word);
  endtask

  task automatic consume(input logic src, input logic [31:0] imm);
    instr_ready = 1'b1;
    PCSrc       = src;
    ImmExt      = imm;
    step();
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    ImmExt      = 32'd0;
  endtask

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    instr_ready = 1'b0; PCSrc = 1'b0; ImmExt = 32'd0;
    step(); step();
    reset = 1'b0;
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);

    // Basic fetch and field decode, then hold with ready low.
    fetch(32'h0062_02B3, 0, 0);
    check("op", {25'd0, op}, 32'h33);
    check("funct3", {29'd0, funct3}, 32'd0);
    check("funct7b5", {31'd0, funct7b5}, 32'd0);
    check("pc0", pc, 32'h0);
    check("pc_plus4_0", pc_plus4, 32'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, 32'h0062_02B3);
      check("hold_pc", pc, 32'h0);
      check("hold_req", {31'd0, imem_req}, 32'd0);
    end
    consume(1'b0, 32'hDEAD_BEEF);
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("seq_req", {31'd0, imem_req}, 32'd1);

    // Decode of nonzero funct3/funct7b5.
    fetch(32'h4000_5033, 0, 0);
    check("op_b", {25'd0, op}, 32'h33);
    check("funct3_b", {29'd0, funct3}, 32'd5);
    check("funct7b5_b", {31'd0, funct7b5}, 32'd1);
    consume(1'b0, 32'd0);
    check("addr8", imem_addr, 32'h8);

    // Delayed grant, then a backward branch to 0.
    fetch(32'h0000_0063, 4, 0);
    consume(1'b1, 32'hFFFF_FFF8);
    check("branch_back", imem_addr, 32'h0);

    // Back to pc=8, then a misaligned branch target.
    fetch(32'h0000_0013, 0, 1);
    consume(1'b0, 32'd0);
    fetch(32'h0000_0013, 0, 0);
    consume(1'b0, 32'd0);
    check("addr8_again", imem_addr, 32'h8);
    fetch(32'h0000_0063, 0, 0);
    consume(1'b1, 32'h0000_0006);
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    check("mis_valid", {31'd0, instr_valid}, 32'd0);
    check("mis_pc", pc, 32'h8);
    imem_gnt = 1'b1;
    step(); step();
    imem_gnt = 1'b0;
    check("err_sticky", {31'd0, fetch_err}, 32'd1);
    check("err_req_low", {31'd0, imem_req}, 32'd0);

    // Reset from S_ERR, then a stray rvalid in S_REQ.
    do_reset();
    check("rerr_valid", {31'd0, instr_valid}, 32'd0);
    check("rerr_err", {31'd0, fetch_err}, 32'd0);
    check("rerr_req", {31'd0, imem_req}, 32'd1);
    check("rerr_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_rvalid = 1'b0;
    check("spur_req", {31'd0, imem_req}, 32'd1);
    check("spur_valid", {31'd0, instr_valid}, 32'd0);
    check("spur_instr", instr, 32'h0);

    // Wait timeout: TMO cycles without rvalid.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      step();
      check("tmo_err", {31'd0, fetch_err}, (i == TMO - 1) ? 32'd1 : 32'd0);
    end
    check("tmo_req", {31'd0, imem_req}, 32'd0);

    // rvalid on the last allowed wait cycle is accepted.
    do_reset();
    fetch(32'h0000_0033, 0, TMO - 1);
    check("last_ok_err", {31'd0, fetch_err}, 32'd0);

    // Reset from S_HOLD.
    do_reset();
    check("rhold_valid", {31'd0, instr_valid}, 32'd0);
    check("rhold_err", {31'd0, fetch_err}, 32'd0);
    check("rhold_req", {31'd0, imem_req}, 32'd1);
    check("rhold_addr", imem_addr, 32'h0);
    check("rhold_instr", instr, 32'h0);

    // PC wrap at the top of the address space.
    fetch(32'h0000_0063, 0, 0);
    consume(1'b1, 32'hFFFF_FFFC);
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_plus4", pc_plus4, 32'h0);
    fetch(32'h0000_0013, 0, 0);
    check("top_hold_plus4", pc_plus4, 32'h0);
    consume(1'b0, 32'd0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_err", {31'd0, fetch_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
